// File: rtl/key_input_pkg.sv
// key_input_pkg: shared widths and register offsets for the key input block.
//   KEY_NUM  - number of push-button channels
//   DATA_W   - CPU data bus width
//   ADDR_W   - register byte-offset width
//   CNT_W    - per-channel debounce counter width
//   ADDR_*   - register byte offsets (STATE, EVENT, IRQ_EN)
package key_input_pkg;

  localparam int unsigned KEY_NUM = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [ADDR_W-1:0] ADDR_STATE  = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_EVENT  = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = 4'h8;

endpackage

// File: rtl/key_input_debounce.sv
// key_debounce: one push-button channel -- 2-flop synchronizer, mismatch
// counter and accepted (stable) level.
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   key_i   - raw asynchronous key level
//   level_o - debounced level (registered)
//   rise_o  - high in the cycle whose closing edge accepts a 0->1 change
//             (combinational, so the consumer can act on that same edge)
module key_debounce
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mismatch_c;
  logic             accept_c;

  // A change is accepted once the mismatch has been seen DEBOUNCE_CYCLES times in a row.
  always_comb begin
    mismatch_c = sync2_q ^ level_q;
    accept_c   = mismatch_c && (cnt_q == CNT_LAST);
  end

  // Synchronizer, counter and stable level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      // Counter is bounded by CNT_LAST, so it never wraps.
      if (!mismatch_c || accept_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept_c) begin
        level_q <= ~level_q;
      end
    end
  end

  assign level_o = level_q;
  // Accepting a mismatch while the synchronized level is 1 means stable goes 0->1.
  assign rise_o  = accept_c & sync2_q;

endmodule

// File: rtl/key_input.sv
// key_input: four debounced push-buttons with a small CPU register window.
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   key_i   - raw push-buttons, active-high
//   ce_i    - register access enable
//   we_i    - write strobe (qualified by ce_i)
//   addr_i  - register byte offset: 0x0 STATE, 0x4 EVENT (W1C), 0x8 IRQ_EN
//   data_i  - write data
//   data_o  - combinational read data (0 when not reading or unmapped)
//   irq_o   - registered level interrupt, |(EVENT & IRQ_EN) of previous edge
module key_input
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_NUM-1:0] key_i,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              irq_o
);

  logic [KEY_NUM-1:0] level;
  logic [KEY_NUM-1:0] rise;
  logic [KEY_NUM-1:0] event_q;
  logic [KEY_NUM-1:0] irq_en_q;
  logic               irq_q;
  logic               wr_c;
  logic [KEY_NUM-1:0] event_clr_c;
  logic [KEY_NUM-1:0] event_d_c;
  logic               unused_data_hi;

  // Only the low KEY_NUM data bits carry register content.
  assign unused_data_hi = ^data_i[DATA_W-1:KEY_NUM];

  // One debounce channel per key.
  for (genvar n = 0; n < KEY_NUM; n++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_i  (key_i[n]),
      .level_o(level[n]),
      .rise_o (rise[n])
    );
  end

  // Write decode and EVENT next value; a new press wins over a coincident clear.
  always_comb begin
    wr_c        = ce_i & we_i;
    event_clr_c = '0;
    if (wr_c && (addr_i == ADDR_EVENT)) begin
      event_clr_c = data_i[KEY_NUM-1:0];
    end
    event_d_c = (event_q & ~event_clr_c) | rise;
  end

  // EVENT, IRQ_EN and the registered interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_q  <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      event_q <= event_d_c;
      if (wr_c && (addr_i == ADDR_IRQ_EN)) begin
        irq_en_q <= data_i[KEY_NUM-1:0];
      end
      irq_q <= |(event_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;

  // Combinational read mux.
  always_comb begin
    data_o = '0;
    if (ce_i && !we_i) begin
      case (addr_i)
        ADDR_STATE:  data_o = DATA_W'(level);
        ADDR_EVENT:  data_o = DATA_W'(event_q);
        ADDR_IRQ_EN: data_o = DATA_W'(irq_en_q);
        default:     data_o = '0;
      endcase
    end
  end

endmodule
